// File: rtl/pool_window_8_4_pkg.sv
// pool_pkg: constants and types shared between the window former
// (pool_window_8_4) and the downstream 2x2 max-pool stage.
//   DATA_W / POOL_IN_W : pixel width and packed 2x2 window width
//   MAP_W / MAP_H      : default feature-map size
//   WIN_PER_FRAME      : windows per 8x8 frame
//   CLAMP_LO/CLAMP_HI  : index clamp bounds shared with the pooler
package pool_pkg;

  localparam int DATA_W        = 9;
  localparam int POOL_IN_W     = 36;
  localparam int MAP_W         = 8;
  localparam int MAP_H         = 8;
  localparam int WIN_PER_FRAME = 16;
  localparam int CLAMP_LO      = 0;
  localparam int CLAMP_HI      = 7;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } win_state_e;

  // Window index of the 2x2 block containing pixel (row, col).
  function automatic int unsigned win_index(input int unsigned row,
                                            input int unsigned col,
                                            input int unsigned img_w);
    return (row / 2) * (img_w / 2) + col / 2;
  endfunction

endpackage

// File: rtl/pool_window_8_4_if.sv
// pool_window_8_4_if: pixel-in / window-out bundle of the window former.
//   master : upstream pixel source plus pooler (drives in_valid, in_data, pool_end)
//   slave  : pool_window_8_4 (drives in_ready, win_*, frame_done, timeout_err)
interface pool_window_8_4_if #(
  parameter int DATA_W = pool_pkg::DATA_W
);

  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  win_start;
  logic [4*DATA_W-1:0]   win_data;
  logic                  pool_end;
  logic [3:0]            win_idx;
  logic                  frame_done;
  logic                  timeout_err;

  modport master (
    output in_valid, in_data, pool_end,
    input  in_ready, win_start, win_data, win_idx, frame_done, timeout_err
  );

  modport slave (
    input  in_valid, in_data, pool_end,
    output in_ready, win_start, win_data, win_idx, frame_done, timeout_err
  );

endinterface

// File: rtl/pool_window_8_4_row_buf.sv
// pool_row_buf: one-row line buffer holding the even (top) row of the
// current window row pair.
//   clk              : clock
//   we/waddr/wdata   : write port
//   raddr_a/rdata_a  : combinational read port (top-left, col-1)
//   raddr_b/rdata_b  : combinational read port (top-right, col)
// Contents are not reset; every location is rewritten before it is read.
module pool_row_buf #(
  parameter int IMG_W  = 8,
  parameter int DATA_W = 9
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(IMG_W)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(IMG_W)-1:0] raddr_a,
  input  logic [$clog2(IMG_W)-1:0] raddr_b,
  output logic [DATA_W-1:0]        rdata_a,
  output logic [DATA_W-1:0]        rdata_b
);

  logic [DATA_W-1:0] mem [IMG_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/pool_window_8_4.sv
// pool_window_8_4: forms non-overlapping 2x2 windows from a raster-order
// IMG_W x IMG_H map and hands each to the max-pool stage with a one-cycle
// start pulse, waiting for the pooler's end flag between windows.
//   clk, reset : clock, synchronous active-high reset
//   bus        : pool_window_8_4_if.slave (pixel stream in, window out,
//                pool_end back from pooler, frame_done, timeout_err)
// Optional: define POOL_WIN_TIMEOUT_EN to add a watchdog that abandons a
// window after TIMEOUT_CYC busy cycles and raises sticky timeout_err.
module pool_window_8_4 #(
  parameter int IMG_W       = 8,
  parameter int IMG_H       = 8,
  parameter int DATA_W      = 9,
  parameter int TIMEOUT_CYC = 15
) (
  input logic               clk,
  input logic               reset,
  pool_window_8_4_if.slave  bus
);

  import pool_pkg::*;

  localparam int COL_W   = $clog2(IMG_W);
  localparam int ROW_W   = $clog2(IMG_H);
  localparam int WIN_CNT = (IMG_W / 2) * (IMG_H / 2);

  if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || TIMEOUT_CYC < 1 || WIN_CNT > 16)
  begin : g_cfg_check
    $error("pool_window_8_4: unsupported parameter set");
  end

  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  win_state_e          state_q, state_d;
  logic                win_start_q, win_start_d;
  logic [4*DATA_W-1:0] win_data_q, win_data_d;
  logic [3:0]          win_idx_q, win_idx_d;
  logic [3:0]          win_cnt_q, win_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   prev_pix_q, prev_pix_d;

  logic                busy, completing, end_acc, in_ready_c, accept, issue;
  logic                buf_we, timeout_hit;
  logic [DATA_W-1:0]   buf_tl, buf_tr;

  pool_row_buf #(
    .IMG_W  (IMG_W),
    .DATA_W (DATA_W)
  ) u_row_buf (
    .clk     (clk),
    .we      (buf_we),
    .waddr   (col_q),
    .wdata   (bus.in_data),
    .raddr_a (col_q - COL_W'(1)),
    .raddr_b (col_q),
    .rdata_a (buf_tl),
    .rdata_b (buf_tr)
  );

  // A completing pixel is only held off while the previous window is still
  // out; a same-cycle pool_end frees the slot immediately.
  assign busy       = (state_q == ST_BUSY);
  assign completing = row_q[0] & col_q[0];
  assign end_acc    = bus.pool_end & busy;
  assign in_ready_c = !(busy && !bus.pool_end && completing);
  assign accept     = bus.in_valid & in_ready_c;
  assign issue      = accept & completing;

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    state_d      = state_q;
    win_start_d  = 1'b0;
    win_data_d   = win_data_q;
    win_idx_d    = win_idx_q;
    win_cnt_d    = win_cnt_q;
    frame_done_d = 1'b0;
    prev_pix_d   = prev_pix_q;
    buf_we       = 1'b0;

    if (accept) begin
      if (col_q == COL_W'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_H - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end

      if (!row_q[0]) begin
        buf_we = 1'b1;
      end else if (!col_q[0]) begin
        prev_pix_d = bus.in_data;
      end else begin
        win_start_d = 1'b1;
        win_data_d  = {buf_tl, buf_tr, prev_pix_q, bus.in_data};
        win_idx_d   = 4'(win_index(32'(row_q), 32'(col_q), IMG_W));
      end
    end

    // Issue wins over a coincident end so busy stays set.
    if (issue) begin
      state_d = ST_BUSY;
    end else if (end_acc || timeout_hit) begin
      state_d = ST_IDLE;
    end

    // Timed-out windows never reach here, so they are not counted.
    if (end_acc) begin
      if (win_cnt_q == 4'(WIN_CNT - 1)) begin
        win_cnt_d    = '0;
        frame_done_d = 1'b1;
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q        <= '0;
      row_q        <= '0;
      state_q      <= ST_IDLE;
      win_start_q  <= 1'b0;
      win_data_q   <= '0;
      win_idx_q    <= '0;
      win_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      prev_pix_q   <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      state_q      <= state_d;
      win_start_q  <= win_start_d;
      win_data_q   <= win_data_d;
      win_idx_q    <= win_idx_d;
      win_cnt_q    <= win_cnt_d;
      frame_done_q <= frame_done_d;
      prev_pix_q   <= prev_pix_d;
    end
  end

`ifdef POOL_WIN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             timeout_err_q, timeout_err_d;

  always_comb begin
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = timeout_err_q;
    timeout_hit   = 1'b0;
    if (issue || end_acc) begin
      tmo_cnt_d = '0;
    end else if (busy) begin
      if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
        timeout_hit   = 1'b1;
        timeout_err_d = 1'b1;
        tmo_cnt_d     = '0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.in_ready   = in_ready_c;
  assign bus.win_start  = win_start_q;
  assign bus.win_data   = win_data_q;
  assign bus.win_idx    = win_idx_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_pool_window_8_4.sv
// Testbench for pool_window_8_4: drives 8x8 frames, emulates the pooler's
// end_flag with a programmable delay, and scoreboards every issued window.
module tb_pool_window_8_4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pool_window_8_4_if #(.DATA_W(9)) bus ();

  pool_window_8_4 #(
    .IMG_W       (8),
    .IMG_H       (8),
    .DATA_W      (9),
    .TIMEOUT_CYC (15)
  ) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [39:0] sb_q[$];
  logic [39:0] obs_q[$];
  logic [39:0] ref_q[$];
  logic [8:0]  frame [64];
  int          stall_log [64];
  logic        ws_log [64];

  // pooler stub
  int   pool_delay = 4;
  int   pend       = 0;
  bit   stub_en    = 1'b1;
  logic stub_end   = 1'b0;
  logic force_end  = 1'b0;
  assign bus.pool_end = stub_end | force_end;

  always @(negedge clk) begin
    if (stub_en) begin
      stub_end = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) stub_end = 1'b1;
      end
      if (bus.win_start) pend = pool_delay;
    end
  end

  // monitor: window scoreboard and frame_done timing
  bit mon_out  = 1'b0;
  int mon_ends = 0;
  int n_starts = 0;
  int n_fd     = 0;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mon_out  = 1'b0;
      mon_ends = 0;
    end else begin
      logic        end_ok, exp_fd;
      logic [39:0] exp_w, got_w;
      end_ok = bus.pool_end && mon_out;
      if (end_ok || bus.frame_done) begin
        exp_fd = end_ok && (mon_ends == 15);
        n_checks++;
        if (bus.frame_done !== exp_fd) begin
          n_fail++;
          $display("FAIL frame_done_timing: got %0b, required %0b (end #%0d)", bus.frame_done, exp_fd, mon_ends);
        end
      end
      if (end_ok) mon_ends = (mon_ends == 15) ? 0 : mon_ends + 1;
      if (bus.frame_done) n_fd++;
      if (bus.win_start) begin
        n_starts++;
        got_w = {bus.win_idx, bus.win_data};
        obs_q.push_back(got_w);
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_win_start: got idx %0d data %h, required no pulse", bus.win_idx, bus.win_data);
        end else begin
          exp_w = sb_q.pop_front();
          if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL window_data: got idx %0d data %h, required idx %0d data %h", got_w[39:36], got_w[35:0], exp_w[39:36], exp_w[35:0]);
          end
        end
      end
      mon_out = bus.win_start ? 1'b1 : (end_ok ? 1'b0 : mon_out);
    end
  end

  task automatic load_ramp();
    for (int i = 0; i < 64; i++) frame[i] = 9'(i);
  endtask

  task automatic send_range(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int r, c;
      bit ok;
      r = i / 8;
      c = i % 8;
      if ((r % 2 == 1) && (c % 2 == 1))
        sb_q.push_back({4'((r / 2) * 4 + c / 2), frame[i-9], frame[i-8], frame[i-1], frame[i]});
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      stall_log[i] = 0;
      forever begin
        #1 ok = bus.in_ready;
        @(posedge clk);
        @(negedge clk);
        if (ok) break;
        stall_log[i]++;
        if (stall_log[i] > 200) begin
          n_checks++;
          n_fail++;
          $display("FAIL stall_limit: pixel %0d in_ready 0 for %0d cycles, required 1", i, stall_log[i]);
          break;
        end
      end
      ws_log[i] = bus.win_start;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while ((sb_q.size() != 0 || mon_out) && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb_q.size() != 0 || mon_out) begin
      n_fail++;
      $display("FAIL idle_limit: %0d windows pending, outstanding %0b, required 0 and 0", sb_q.size(), mon_out);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.win_start !== 1'b0)   begin n_fail++; $display("FAIL reset_win_start: got %0b, required 0", bus.win_start); end
    n_checks++; if (bus.win_data !== 36'h0)   begin n_fail++; $display("FAIL reset_win_data: got %h, required 0", bus.win_data); end
    n_checks++; if (bus.win_idx !== 4'h0)     begin n_fail++; $display("FAIL reset_win_idx: got %0d, required 0", bus.win_idx); end
    n_checks++; if (bus.frame_done !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_done: got %0b, required 0", bus.frame_done); end
    n_checks++; if (bus.timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b, required 0", bus.timeout_err); end
    n_checks++; if (bus.in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %0b, required 1", bus.in_ready); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp_frame();
    int s0 = n_starts;
    int f0 = n_fd;
    load_ramp();
    pool_delay = 4;
    obs_q.delete();
    send_range(0, 63);
    wait_idle();
    n_checks++; if (n_starts - s0 != 16) begin n_fail++; $display("FAIL ramp_start_count: got %0d, required 16", n_starts - s0); end
    n_checks++; if (n_fd - f0 != 1)      begin n_fail++; $display("FAIL ramp_frame_done_count: got %0d, required 1", n_fd - f0); end
    n_checks++; if (obs_q[0] !== {4'd0, 9'd0, 9'd1, 9'd8, 9'd9})
      begin n_fail++; $display("FAIL ramp_first_window: got %h, required %h", obs_q[0], {4'd0, 9'd0, 9'd1, 9'd8, 9'd9}); end
    n_checks++; if (obs_q[15] !== {4'd15, 9'd54, 9'd55, 9'd62, 9'd63})
      begin n_fail++; $display("FAIL ramp_last_window: got %h, required %h", obs_q[15], {4'd15, 9'd54, 9'd55, 9'd62, 9'd63}); end
    ref_q = obs_q;
  endtask

  task automatic test_coincidence();
    int s0 = n_starts;
    load_ramp();
    pool_delay = 4;
    obs_q.delete();
    send_range(0, 63);
    wait_idle();
    n_checks++; if (stall_log[9] != 0)  begin n_fail++; $display("FAIL coin_first_stall: got %0d, required 0", stall_log[9]); end
    n_checks++; if (stall_log[11] != 3) begin n_fail++; $display("FAIL coin_accept_on_end: got %0d stalls, required 3", stall_log[11]); end
    n_checks++; if (ws_log[11] !== 1'b1) begin n_fail++; $display("FAIL coin_start_next_cycle: got %0b, required 1", ws_log[11]); end
    n_checks++; if (stall_log[13] != 3) begin n_fail++; $display("FAIL coin_busy_kept: got %0d stalls, required 3", stall_log[13]); end
    n_checks++; if (n_starts - s0 != 16) begin n_fail++; $display("FAIL coin_start_count: got %0d, required 16", n_starts - s0); end
  endtask

  task automatic test_backpressure();
    int free_stalls = 0;
    int bad = 0;
    load_ramp();
    pool_delay = 10;
    obs_q.delete();
    send_range(0, 63);
    wait_idle();
    for (int i = 0; i < 64; i++)
      if (!((i / 8) % 2 == 1 && (i % 8) % 2 == 1)) free_stalls += stall_log[i];
    n_checks++; if (free_stalls != 0)   begin n_fail++; $display("FAIL bp_noncompleting_stall: got %0d, required 0", free_stalls); end
    n_checks++; if (stall_log[9] != 0)  begin n_fail++; $display("FAIL bp_first_stall: got %0d, required 0", stall_log[9]); end
    n_checks++; if (stall_log[11] != 9) begin n_fail++; $display("FAIL bp_row1_col3_stall: got %0d, required 9", stall_log[11]); end
    if (obs_q.size() != ref_q.size()) bad = 99;
    else for (int k = 0; k < obs_q.size(); k++) if (obs_q[k] !== ref_q[k]) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_windows_vs_ramp: got %0d differing windows, required 0", bad); end
    pool_delay = 4;
  endtask

  task automatic test_signed();
    logic [39:0] w;
    load_ramp();
    frame[0] = 9'h100;
    frame[1] = 9'h0FF;
    frame[8] = 9'h1FF;
    frame[9] = 9'h000;
    pool_delay = 4;
    obs_q.delete();
    send_range(0, 63);
    wait_idle();
    w = obs_q[0];
    n_checks++; if (w[35:0] !== 36'h8_03FF_FE00) begin n_fail++; $display("FAIL signed_window: got %h, required 803fffe00", w[35:0]); end
    n_checks++; if (w[39:36] !== 4'd0) begin n_fail++; $display("FAIL signed_idx: got %0d, required 0", w[39:36]); end
  endtask

  task automatic test_reset_midframe();
    int s0, f0;
    logic [39:0] w;
    load_ramp();
    pool_delay = 4;
    send_range(0, 19);
    #1;
    rst       = 1'b1;
    stub_en   = 1'b0;
    pend      = 0;
    stub_end  = 1'b0;
    force_end = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.win_start !== 1'b0)  begin n_fail++; $display("FAIL midrst_win_start: got %0b, required 0", bus.win_start); end
    n_checks++; if (bus.win_idx !== 4'h0)    begin n_fail++; $display("FAIL midrst_win_idx: got %0d, required 0", bus.win_idx); end
    n_checks++; if (bus.win_data !== 36'h0)  begin n_fail++; $display("FAIL midrst_win_data: got %h, required 0", bus.win_data); end
    n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_done: got %0b, required 0", bus.frame_done); end
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1 force_end = 1'b0;
    sb_q.delete();
    obs_q.delete();
    s0 = n_starts;
    f0 = n_fd;
    stub_en = 1'b1;
    send_range(0, 63);
    wait_idle();
    w = obs_q[0];
    n_checks++; if (w !== {4'd0, 9'd0, 9'd1, 9'd8, 9'd9}) begin n_fail++; $display("FAIL midrst_first_window: got %h, required %h", w, {4'd0, 9'd0, 9'd1, 9'd8, 9'd9}); end
    n_checks++; if (n_starts - s0 != 16) begin n_fail++; $display("FAIL midrst_start_count: got %0d, required 16", n_starts - s0); end
    n_checks++; if (n_fd - f0 != 1)      begin n_fail++; $display("FAIL midrst_frame_done_count: got %0d, required 1", n_fd - f0); end
  endtask

`ifdef POOL_WIN_TIMEOUT_EN
  task automatic test_timeout();
    int cyc = 0;
    load_ramp();
    stub_en  = 1'b0;
    pend     = 0;
    stub_end = 1'b0;
    send_range(0, 9);
    while (!bus.timeout_err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 15) begin n_fail++; $display("FAIL timeout_latency: got %0d cycles, required 15", cyc); end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0b, required 1", bus.timeout_err); end
    send_range(10, 11);
    n_checks++; if (stall_log[11] != 0) begin n_fail++; $display("FAIL timeout_resume_stall: got %0d, required 0", stall_log[11]); end
    n_checks++; if (ws_log[11] !== 1'b1) begin n_fail++; $display("FAIL timeout_resume_start: got %0b, required 1", ws_log[11]); end
    repeat (3) @(negedge clk);
    n_checks++; if (sb_q.size() != 0) begin n_fail++; $display("FAIL timeout_pending: got %0d, required 0", sb_q.size()); end
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    test_reset();
    test_ramp_frame();
    test_coincidence();
    test_backpressure();
    test_signed();
    test_reset_midframe();
`ifdef POOL_WIN_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_time_limit: simulation still running, required to finish");
    $fatal(1, "time limit");
  end

endmodule
